move_scheduler: RTL and testbench
=================================

MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  synchronous active-low reset.
REQ-004 start  input  1  request a move decision; accepted only in IDLE.
REQ-005 me_is_x  input  1  1: block plays X; 0: block plays O; latched at start.
REQ-006 xin  input  9  X occupancy, bit i = square i (row-major, 0 = top-left); latched at start.
REQ-007 oin  input  9  O occupancy, same mapping; latched at start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse when result outputs become valid.
REQ-010 move  output  9  one-hot chosen square; 0 if none.
REQ-011 move_valid  output  1  1 when move is a legal empty square.
REQ-012 move_kind  output  2  00 NONE, 01 WIN, 10 BLOCK, 11 FALLBACK.

Function
REQ-013 Line table (line index: squares in element order 0,1,2): 0:0,1,2; 1:3,4,5; 2:6,7,8; 3:0,3,6; 4:1,4,7; 5:2,5,8; 6:0,4,8; 7:2,4,6.
REQ-014 Per-line test: with a = mover bits and b = opponent bits for the line, element j is a hit iff a is set on the other two elements and neither a nor b is set on element j.
REQ-015 One line is evaluated per cycle; exactly one line-test instance is shared across both scan phases.
REQ-016 States: IDLE, WIN, BLOCK, FALLBACK, DONE.
REQ-017 IDLE: when start=1, latch xin/oin/me_is_x, set line index to 0, go to WIN; start=0 stays in IDLE.
REQ-018 WIN: a = own pieces, b = opponent pieces; on hit go to DONE with kind WIN; else increment index; after line 7, go to BLOCK with index 0.
REQ-019 BLOCK: a = opponent pieces, b = own pieces; on hit go to DONE with kind BLOCK; after line 7 with no hit, go to FALLBACK.
REQ-020 FALLBACK: pick the first empty square in the order 4, 0, 2, 6, 8, 1, 3, 5, 7, with kind FALLBACK; if none is empty, move=0, move_valid=0, kind NONE; next state DONE.
REQ-021 A square is empty iff both its xin and oin bits are 0; a square with both bits set is treated as occupied.
REQ-022 If multiple elements in one line hit, the lowest element index is selected.
REQ-023 Timing, with start accepted in cycle T: WIN hit on line k gives done=1 in cycle T+2+k; BLOCK hit on line k gives done=1 in cycle T+10+k; FALLBACK gives done=1 in cycle T+18.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE.
REQ-025 move, move_valid and move_kind are registered, update in the cycle done rises, and hold until the next done or reset.
REQ-026 start asserted while busy=1 (including DONE) SHALL be ignored, with no queuing.
REQ-027 Input changes on xin, oin and me_is_x after the accept cycle SHALL NOT affect the result.

Reset
REQ-028 When reset_n=0 at a clock edge, in any state, the next state SHALL be IDLE with busy=0, done=0, move=0, move_valid=0, move_kind=00, and line index 0.
REQ-029 Reset asserted mid-scan SHALL abort the scan with no done pulse; the first start after reset is accepted normally.

Verification
REQ-030 Win detection: me_is_x=1, xin=9'b000000011, oin=9'b000011000, start at T -> done at T+2, move=9'b000000100, move_kind=01, move_valid=1.
REQ-031 Block detection: me_is_x=1, xin=9'b000000001, oin=9'b100100000 -> done at T+15, move=9'b000000100, move_kind=10.
REQ-032 Priority and role swap: me_is_x=0, oin=9'b000000011, xin=9'b000011000 -> WIN on line 0 at T+2, move=9'b000000100; the X threat on line 1 is not reported.
REQ-033 Fallback and full board: an all-zero board gives done at T+18, move=9'b000010000, kind=11. A full board (xin=9'b101011010, oin=9'b010100101) gives move=0, move_valid=0, kind=00.
REQ-034 Control edge cases: a start pulse at T+5 of an active scan has no effect. reset_n=0 at T+12 gives busy=0, move=0, and no done pulse; a start after reset gives correct timing.

Source files
------------

// File: rtl/move_scheduler.sv
// Tic-tac-toe move picker: scans the eight lines for a win, then for a block,
// then falls back to a fixed square preference order.
module move_scheduler (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       me_is_x,
    input  logic [8:0] xin,
    input  logic [8:0] oin,
    output logic       busy,
    output logic       done,
    output logic [8:0] move,
    output logic       move_valid,
    output logic [1:0] move_kind
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WIN   = 3'd1;
    localparam logic [2:0] S_BLOCK = 3'd2;
    localparam logic [2:0] S_FALL  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] K_NONE  = 2'b00;
    localparam logic [1:0] K_WIN   = 2'b01;
    localparam logic [1:0] K_BLOCK = 2'b10;
    localparam logic [1:0] K_FALL  = 2'b11;

    logic [2:0] state;
    logic [2:0] idx;
    logic [8:0] xr;
    logic [8:0] orr;
    logic       me_x;

    logic [3:0] sq0, sq1, sq2;
    logic [8:0] own, opp, a, b;
    logic       a0, a1, a2, b0, b1, b2;
    logic       h0, h1, h2, hit;
    logic [3:0] hit_sq;
    logic [8:0] hit_mask;
    logic [8:0] empty;
    logic [8:0] fb;

    // Square indices of the line currently being scanned
    always_comb begin
        sq0 = 4'd0;
        sq1 = 4'd1;
        sq2 = 4'd2;
        case (idx)
            3'd0: begin sq0 = 4'd0; sq1 = 4'd1; sq2 = 4'd2; end
            3'd1: begin sq0 = 4'd3; sq1 = 4'd4; sq2 = 4'd5; end
            3'd2: begin sq0 = 4'd6; sq1 = 4'd7; sq2 = 4'd8; end
            3'd3: begin sq0 = 4'd0; sq1 = 4'd3; sq2 = 4'd6; end
            3'd4: begin sq0 = 4'd1; sq1 = 4'd4; sq2 = 4'd7; end
            3'd5: begin sq0 = 4'd2; sq1 = 4'd5; sq2 = 4'd8; end
            3'd6: begin sq0 = 4'd0; sq1 = 4'd4; sq2 = 4'd8; end
            default: begin sq0 = 4'd2; sq1 = 4'd4; sq2 = 4'd6; end
        endcase
    end

    // Single shared line test; roles of a/b swap between the two scan phases
    always_comb begin
        own = me_x ? xr : orr;
        opp = me_x ? orr : xr;
        a = (state == S_BLOCK) ? opp : own;
        b = (state == S_BLOCK) ? own : opp;
        a0 = a[sq0];
        a1 = a[sq1];
        a2 = a[sq2];
        b0 = b[sq0];
        b1 = b[sq1];
        b2 = b[sq2];
        h0 = a1 & a2 & ~a0 & ~b0;
        h1 = a0 & a2 & ~a1 & ~b1;
        h2 = a0 & a1 & ~a2 & ~b2;
        hit = h0 | h1 | h2;
        if (h0)
            hit_sq = sq0;
        else if (h1)
            hit_sq = sq1;
        else
            hit_sq = sq2;
        hit_mask = 9'd1 << hit_sq;
    end

    // Fallback square: first empty one in preference order 4,0,2,6,8,1,3,5,7
    always_comb begin
        empty = ~(xr | orr);
        fb = 9'd0;
        if (empty[4])      fb = 9'h010;
        else if (empty[0]) fb = 9'h001;
        else if (empty[2]) fb = 9'h004;
        else if (empty[6]) fb = 9'h040;
        else if (empty[8]) fb = 9'h100;
        else if (empty[1]) fb = 9'h002;
        else if (empty[3]) fb = 9'h008;
        else if (empty[5]) fb = 9'h020;
        else if (empty[7]) fb = 9'h080;
    end

    // Control FSM, board snapshot and registered result
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            idx        <= 3'd0;
            xr         <= 9'd0;
            orr        <= 9'd0;
            me_x       <= 1'b0;
            move       <= 9'd0;
            move_valid <= 1'b0;
            move_kind  <= K_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        xr    <= xin;
                        orr   <= oin;
                        me_x  <= me_is_x;
                        idx   <= 3'd0;
                        state <= S_WIN;
                    end
                end
                S_WIN: begin
                    if (hit) begin
                        move       <= hit_mask;
                        move_valid <= 1'b1;
                        move_kind  <= K_WIN;
                        state      <= S_DONE;
                    end else if (idx == 3'd7) begin
                        idx   <= 3'd0;
                        state <= S_BLOCK;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                S_BLOCK: begin
                    if (hit) begin
                        move       <= hit_mask;
                        move_valid <= 1'b1;
                        move_kind  <= K_BLOCK;
                        state      <= S_DONE;
                    end else if (idx == 3'd7) begin
                        idx   <= 3'd0;
                        state <= S_FALL;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                S_FALL: begin
                    move       <= fb;
                    move_valid <= |fb;
                    move_kind  <= (|fb) ? K_FALL : K_NONE;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    idx   <= 3'd0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_move_scheduler.sv
// Self-checking bench for move_scheduler: directed cases plus random boards
// compared against a line-table reference model.
module tb_move_scheduler;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       me_is_x;
    logic [8:0] xin;
    logic [8:0] oin;
    logic       busy;
    logic       done;
    logic [8:0] move;
    logic       move_valid;
    logic [1:0] move_kind;

    int checks = 0;
    int failures = 0;

    int lt [8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
                      '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
                      '{0, 4, 8}, '{2, 4, 6}};
    int fb_order [9] = '{4, 0, 2, 6, 8, 1, 3, 5, 7};

    move_scheduler dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .me_is_x    (me_is_x),
        .xin        (xin),
        .oin        (oin),
        .busy       (busy),
        .done       (done),
        .move       (move),
        .move_valid (move_valid),
        .move_kind  (move_kind)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: latency in cycles after accept, chosen move and kind
    task automatic ref_model(input logic [8:0] x, input logic [8:0] o,
                             input logic me, output int lat,
                             output logic [8:0] mv, output logic vld,
                             output logic [1:0] kind);
        logic [8:0] own, opp, a, b;
        bit found;
        found = 0;
        own = me ? x : o;
        opp = me ? o : x;
        lat = 18;
        mv = 9'd0;
        vld = 1'b0;
        kind = 2'b00;
        for (int ph = 0; ph < 2 && !found; ph++) begin
            a = (ph == 0) ? own : opp;
            b = (ph == 0) ? opp : own;
            for (int k = 0; k < 8 && !found; k++) begin
                for (int j = 0; j < 3 && !found; j++) begin
                    int s, p, q;
                    s = lt[k][j];
                    p = lt[k][(j + 1) % 3];
                    q = lt[k][(j + 2) % 3];
                    if (a[p] && a[q] && !a[s] && !b[s]) begin
                        found = 1;
                        lat = 2 + 8 * ph + k;
                        mv = 9'd0;
                        mv[s] = 1'b1;
                        vld = 1'b1;
                        kind = (ph == 0) ? 2'b01 : 2'b10;
                    end
                end
            end
        end
        for (int i = 0; i < 9 && !found; i++) begin
            if (!x[fb_order[i]] && !o[fb_order[i]]) begin
                found = 1;
                mv = 9'd0;
                mv[fb_order[i]] = 1'b1;
                vld = 1'b1;
                kind = 2'b11;
            end
        end
    endtask

    // mode 0: plain run, 1: extra start at T+5, 2: reset at T+12
    task automatic run(input logic [8:0] x, input logic [8:0] o,
                       input logic me, input int mode);
        int lat, n;
        logic [8:0] emv;
        logic evld;
        logic [1:0] ekind;
        bit got;
        int seen;
        ref_model(x, o, me, lat, emv, evld, ekind);
        @(negedge clk);
        xin = x;
        oin = o;
        me_is_x = me;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        xin = 9'($urandom);
        oin = 9'($urandom);
        me_is_x = ~me;
        chk("busy_after_accept", busy, 1);
        n = 0;
        got = 0;
        while (n < 40 && !got) begin
            @(negedge clk);
            n++;
            start = (mode == 1 && n == 5);
            if (mode == 2 && n == 12) begin
                chk("no_done_before_reset", done, 0);
                reset_n = 1'b0;
                @(posedge clk);
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_move", move, 0);
                chk("rst_valid", move_valid, 0);
                chk("rst_kind", move_kind, 0);
                @(negedge clk);
                reset_n = 1'b1;
                seen = 0;
                for (int i = 0; i < 12; i++) begin
                    @(negedge clk);
                    if (done) seen++;
                end
                chk("aborted_no_done", seen, 0);
                chk("idle_after_abort", busy, 0);
                return;
            end
            if (done) got = 1;
        end
        chk("timeout", got, 1);
        if (!got) return;
        chk("latency", n, lat);
        chk("move", move, emv);
        chk("move_valid", move_valid, evld);
        chk("move_kind", move_kind, ekind);
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
        chk("move_hold", move, emv);
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        me_is_x = 1'b0;
        xin = 9'd0;
        oin = 9'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_move", move, 0);
        chk("reset_valid", move_valid, 0);
        chk("reset_kind", move_kind, 0);
        @(negedge clk);
        reset_n = 1'b1;

        run(9'b000000011, 9'b000011000, 1'b1, 0);
        run(9'b000000001, 9'b100100000, 1'b1, 0);
        run(9'b000011000, 9'b000000011, 1'b0, 0);
        run(9'b000000000, 9'b000000000, 1'b1, 0);
        run(9'b101011010, 9'b010100101, 1'b0, 0);
        run(9'b000000001, 9'b100100000, 1'b1, 1);
        run(9'b000000000, 9'b000000000, 1'b0, 2);
        run(9'b000000000, 9'b000000000, 1'b0, 0);
        run(9'b000000011, 9'b000011000, 1'b1, 0);

        for (int i = 0; i < 60; i++) begin
            logic [8:0] x, o;
            x = 9'($urandom) & 9'($urandom);
            o = 9'($urandom) & 9'($urandom);
            if ($urandom_range(0, 3) != 0) o = o & ~x;
            run(x, o, 1'($urandom), int'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
